// File: rtl/ascii_cmd_decoder_if.sv
// Byte-stream input and single-beat bus bundle for the ASCII command decoder.
// The master modport is the decoder side: it consumes the RX stream and drives the bus.
interface ascii_cmd_decoder_if #(
   parameter int ADDR_SIZE = 16,
   parameter int WORD_SIZE = 32
);
   logic                 s_axis_tvalid;
   logic [7:0]           s_axis_tdata;
   logic                 s_axis_tready;
   logic [ADDR_SIZE-1:0] addr;
   logic [WORD_SIZE-1:0] wdata;
   logic                 we;
   logic                 cs;
   logic                 ack;

   modport master (
      input  s_axis_tvalid, s_axis_tdata, ack,
      output s_axis_tready, addr, wdata, we, cs
   );

   modport slave (
      output s_axis_tvalid, s_axis_tdata, ack,
      input  s_axis_tready, addr, wdata, we, cs
   );
endinterface

// File: rtl/ascii_cmd_decoder.sv
// Buffers one ASCII command line, decodes start/stop/reset/read/write with hex
// arguments, and runs the resulting single-beat bus cycle or core control action.
module ascii_cmd_decoder #(
   parameter int ADDR_SIZE  = 16,
   parameter int WORD_SIZE  = 32,
   parameter int MAX_LINE   = 32,
   parameter int RST_CYCLES = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   ascii_cmd_decoder_if.master  bus,
   output logic                 irq,
   output logic                 req_rst,
   output logic                 done,
   output logic                 err,
   output logic [2:0]           err_code
);
   localparam int ADDR_DIGITS = ADDR_SIZE / 4;
   localparam int WORD_DIGITS = WORD_SIZE / 4;
   localparam int PW          = $clog2(MAX_LINE + 1);
   localparam int DEPTH       = 1 << PW;
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
   localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK_CMD, S_PARSE_ADDR, S_PARSE_DATA, S_READ,
      S_WRITE, S_START, S_STOP, S_RESET, S_ERROR
   } state_t;

   state_t               state, next_state;
   logic [7:0]           line_buf [DEPTH];
   logic [PW-1:0]        ptr, idx;
   logic                 ovf, cmd_write;
   logic [ADDR_SIZE-1:0] addr_acc;
   logic [WORD_SIZE-1:0] data_acc;
   logic [7:0]           ndig;
   logic [31:0]          cnt;
   logic [2:0]           code_r, set_code;
   logic                 ld_cmd, sh_addr, sh_data, skip_sp;
   logic                 done_set, irq_clr, irq_set;
   logic                 accept, is_lf, is_cr;
   logic [7:0]           ch;
   logic [4:0]           hv;
   logic [39:0]          line5;
   logic [47:0]          line6;
   logic                 kw_start, kw_stop, kw_reset, kw_read, kw_write;

   // Returns {valid, nibble} for an ASCII hex digit.
   function automatic logic [4:0] hex_val(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
      if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
         return {1'b1, 4'(c[3:0] + 4'd9)};
      return 5'd0;
   endfunction

   assign accept = bus.s_axis_tready & bus.s_axis_tvalid & (state == S_IDLE);
   assign is_lf  = (bus.s_axis_tdata == 8'h0A);
   assign is_cr  = (bus.s_axis_tdata == 8'h0D);
   assign ch     = line_buf[idx];
   assign hv     = hex_val(ch);

   assign line5    = {line_buf[0], line_buf[1], line_buf[2], line_buf[3], line_buf[4]};
   assign line6    = {line5, line_buf[5]};
   assign kw_start = (ptr == PW'(5)) && (line5 == "start");
   assign kw_stop  = (ptr == PW'(4)) && (line5[39:8] == "stop");
   assign kw_reset = (ptr == PW'(5)) && (line5 == "reset");
   assign kw_read  = (ptr >= PW'(5)) && (line5 == "read ");
   assign kw_write = (ptr >= PW'(6)) && (line6 == "write ");

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      set_code   = 3'd0;
      ld_cmd     = 1'b0;
      sh_addr    = 1'b0;
      sh_data    = 1'b0;
      skip_sp    = 1'b0;
      done_set   = 1'b0;
      irq_clr    = 1'b0;
      irq_set    = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept && is_lf && (ptr != '0 || ovf)) next_state = S_CHECK_CMD;
         end
         S_CHECK_CMD: begin
            ld_cmd = 1'b1;
            if (ovf) begin
               next_state = S_ERROR; set_code = 3'd3;
            end else if (kw_start) next_state = S_START;
            else if (kw_stop)      next_state = S_STOP;
            else if (kw_reset || kw_read || kw_write) begin
               if (!irq) begin
                  next_state = S_ERROR; set_code = 3'd4;
               end else if (kw_reset) next_state = S_RESET;
               else                   next_state = S_PARSE_ADDR;
            end else begin
               next_state = S_ERROR; set_code = 3'd1;
            end
         end
         S_PARSE_ADDR: begin
            if (idx == ptr) begin
               if (cmd_write || ndig == 8'd0) begin
                  next_state = S_ERROR; set_code = 3'd2;
               end else next_state = S_READ;
            end else if (ch == 8'h20) begin
               if (!cmd_write || ndig == 8'd0) begin
                  next_state = S_ERROR; set_code = 3'd2;
               end else begin
                  next_state = S_PARSE_DATA; skip_sp = 1'b1;
               end
            end else if (!hv[4] || ndig == 8'(ADDR_DIGITS)) begin
               next_state = S_ERROR; set_code = 3'd2;
            end else sh_addr = 1'b1;
         end
         S_PARSE_DATA: begin
            if (idx == ptr) begin
               if (ndig == 8'd0) begin
                  next_state = S_ERROR; set_code = 3'd2;
               end else next_state = S_WRITE;
            end else if (!hv[4] || ndig == 8'(WORD_DIGITS)) begin
               next_state = S_ERROR; set_code = 3'd2;
            end else sh_data = 1'b1;
         end
         S_READ, S_WRITE: begin
            if (bus.cs && bus.ack) begin
               next_state = S_IDLE; done_set = 1'b1;
            end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
               next_state = S_ERROR; set_code = 3'd5;
            end
         end
         S_START: begin
            next_state = S_IDLE; irq_clr = 1'b1; done_set = 1'b1;
         end
         S_STOP: begin
            next_state = S_IDLE; irq_set = 1'b1; done_set = 1'b1;
         end
         S_RESET: begin
            if (cnt == RST_LAST) begin
               next_state = S_IDLE; done_set = 1'b1;
            end
         end
         S_ERROR:  next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Line storage carries no reset; ptr alone defines which bytes are valid.
   always_ff @(posedge clk) begin
      if (accept && !is_lf && !is_cr && ptr != PW'(MAX_LINE))
         line_buf[ptr] <= bus.s_axis_tdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         ovf       <= 1'b0;
         idx       <= '0;
         cmd_write <= 1'b0;
         addr_acc  <= '0;
         data_acc  <= '0;
         ndig      <= 8'd0;
         cnt       <= 32'd0;
         code_r    <= 3'd0;
      end else begin
         if (state != S_IDLE && next_state == S_IDLE) begin
            ptr <= '0;
            ovf <= 1'b0;
         end else if (accept && !is_lf && !is_cr) begin
            if (ptr == PW'(MAX_LINE)) ovf <= 1'b1;
            else                      ptr <= ptr + PW'(1);
         end
         if (ld_cmd) begin
            idx       <= kw_write ? PW'(6) : PW'(5);
            cmd_write <= kw_write;
            addr_acc  <= '0;
            data_acc  <= '0;
            ndig      <= 8'd0;
         end else if (sh_addr) begin
            addr_acc <= (addr_acc << 4) | ADDR_SIZE'(hv[3:0]);
            ndig     <= ndig + 8'd1;
            idx      <= idx + PW'(1);
         end else if (sh_data) begin
            data_acc <= (data_acc << 4) | WORD_SIZE'(hv[3:0]);
            ndig     <= ndig + 8'd1;
            idx      <= idx + PW'(1);
         end else if (skip_sp) begin
            ndig <= 8'd0;
            idx  <= idx + PW'(1);
         end
         cnt <= (next_state != state) ? 32'd0 : cnt + 32'd1;
         if (next_state == S_ERROR && state != S_ERROR) code_r <= set_code;
      end
   end

   // Outputs are registered from next_state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.s_axis_tready <= 1'b0;
         bus.addr          <= '0;
         bus.wdata         <= '0;
         bus.we            <= 1'b0;
         bus.cs            <= 1'b0;
         irq               <= 1'b1;
         req_rst           <= 1'b0;
         done              <= 1'b0;
         err               <= 1'b0;
         err_code          <= 3'd0;
      end else begin
         bus.s_axis_tready <= (next_state == S_IDLE);
         bus.cs            <= (next_state == S_READ) || (next_state == S_WRITE);
         bus.we            <= (next_state == S_WRITE);
         bus.addr          <= ((next_state == S_READ) || (next_state == S_WRITE)) ? addr_acc : '0;
         bus.wdata         <= (next_state == S_WRITE) ? data_acc : '0;
         req_rst           <= (next_state == S_RESET);
         done              <= done_set;
         err               <= (state == S_ERROR);
         err_code          <= (state == S_ERROR) ? code_r : 3'd0;
         if (irq_clr)      irq <= 1'b0;
         else if (irq_set) irq <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ascii_cmd_decoder.sv
// Directed bench for ascii_cmd_decoder: sends command lines and checks bus, status and timing.
module tb_ascii_cmd_decoder;
   localparam int MAX_LINE = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       irq, req_rst, done, err;
   logic [2:0] err_code;

   int n_checks = 0;
   int n_errors = 0;
   int ack_lat  = -1;
   int cs_run   = 0;

   int          r_cs, r_we, r_rr, r_lat;
   logic        r_done, r_err, r_cs_end;
   logic [2:0]  r_code;
   logic [15:0] r_addr;
   logic [31:0] r_wdata;

   ascii_cmd_decoder_if #(.ADDR_SIZE(16), .WORD_SIZE(32)) bus_if ();

   ascii_cmd_decoder #(
      .ADDR_SIZE(16), .WORD_SIZE(32), .MAX_LINE(MAX_LINE), .RST_CYCLES(16), .TIMEOUT(255)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if),
      .irq      (irq),
      .req_rst  (req_rst),
      .done     (done),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   // Bus responder: acks after ack_lat cycles of cs, never when ack_lat < 0.
   always @(negedge clk) begin
      if (bus_if.cs) begin
         bus_if.ack = (ack_lat >= 0 && cs_run == ack_lat);
         cs_run++;
      end else begin
         bus_if.ack = 1'b0;
         cs_run = 0;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus_if.s_axis_tready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check_eq("tready_wait", 64'(bus_if.s_axis_tready), 64'd1);
      bus_if.s_axis_tvalid = 1'b1;
      bus_if.s_axis_tdata  = b;
      @(posedge clk);
      #1;
      bus_if.s_axis_tvalid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_result(input int limit);
      r_done = 0; r_err = 0; r_code = 0; r_cs = 0; r_we = 0; r_rr = 0;
      r_lat = 0; r_addr = 0; r_wdata = 0; r_cs_end = 0;
      for (int n = 1; n <= limit; n++) begin
         @(negedge clk);
         if (bus_if.cs) begin
            r_cs++;
            r_addr  = bus_if.addr;
            r_wdata = bus_if.wdata;
            if (bus_if.we) r_we++;
         end
         if (req_rst) r_rr++;
         if (done || err) begin
            r_done = done; r_err = err; r_code = err_code; r_lat = n; r_cs_end = bus_if.cs;
            break;
         end
      end
   endtask

   task automatic run_cmd(input string s, input int limit);
      send_str(s);
      send_byte(8'h0A);
      wait_result(limit);
   endtask

   task automatic expect_err(input string tag, input logic [2:0] code);
      check_eq({tag, "_err"}, 64'(r_err), 64'd1);
      check_eq({tag, "_code"}, 64'(r_code), 64'(code));
      check_eq({tag, "_cs"}, 64'(r_cs), 64'd0);
   endtask

   initial begin
      bus_if.s_axis_tvalid = 1'b0;
      bus_if.s_axis_tdata  = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_tready", 64'(bus_if.s_axis_tready), 64'd0);
      check_eq("rst_cs", 64'(bus_if.cs), 64'd0);
      check_eq("rst_we", 64'(bus_if.we), 64'd0);
      check_eq("rst_addr", 64'(bus_if.addr), 64'd0);
      check_eq("rst_wdata", 64'(bus_if.wdata), 64'd0);
      check_eq("rst_irq", 64'(irq), 64'd1);
      check_eq("rst_flags", 64'({req_rst, done, err, err_code}), 64'd0);
      rst = 1'b0;

      // T1: start runs the core with fixed latency; read is then refused.
      run_cmd("start", 20);
      check_eq("start_done", 64'(r_done), 64'd1);
      check_eq("start_lat", 64'(r_lat), 64'd3);
      check_eq("start_irq", 64'(irq), 64'd0);
      run_cmd("read 10", 20);
      expect_err("read_running", 3'd4);

      run_cmd("stop", 20);
      check_eq("stop_done", 64'(r_done), 64'd1);
      check_eq("stop_lat", 64'(r_lat), 64'd3);
      check_eq("stop_irq", 64'(irq), 64'd1);

      // T2: write with CR before LF, immediate ack.
      ack_lat = 0;
      send_str("write 1A 0000BEEF");
      send_byte(8'h0D);
      send_byte(8'h0A);
      wait_result(60);
      check_eq("write_done", 64'(r_done), 64'd1);
      check_eq("write_cs_cycles", 64'(r_cs), 64'd1);
      check_eq("write_we_cycles", 64'(r_we), 64'd1);
      check_eq("write_addr", 64'(r_addr), 64'h001A);
      check_eq("write_wdata", 64'(r_wdata), 64'h0000BEEF);
      check_eq("write_cs_after", 64'(r_cs_end), 64'd0);

      // Read with a 2-cycle delayed ack holds cs for three cycles.
      ack_lat = 2;
      run_cmd("read aBcD", 60);
      check_eq("read_done", 64'(r_done), 64'd1);
      check_eq("read_cs_cycles", 64'(r_cs), 64'd3);
      check_eq("read_we_cycles", 64'(r_we), 64'd0);
      check_eq("read_addr", 64'(r_addr), 64'hABCD);

      // T3: no ack -> timeout after 255 cycles of cs.
      ack_lat = -1;
      run_cmd("read 3", 400);
      check_eq("to_err", 64'(r_err), 64'd1);
      check_eq("to_code", 64'(r_code), 64'd5);
      check_eq("to_cs_cycles", 64'(r_cs), 64'd255);
      check_eq("to_addr", 64'(r_addr), 64'h0003);
      check_eq("to_cs_after", 64'(r_cs_end), 64'd0);

      // T4: reset pulse width.
      run_cmd("reset", 60);
      check_eq("reset_done", 64'(r_done), 64'd1);
      check_eq("reset_cycles", 64'(r_rr), 64'd16);
      check_eq("reset_irq", 64'(irq), 64'd1);

      // T5: overflowing line, then a clean command.
      for (int i = 0; i < MAX_LINE + 5; i++) send_byte(8'h61);
      send_byte(8'h0A);
      wait_result(20);
      check_eq("ovf_code", 64'(r_code), 64'd3);
      run_cmd("stop", 20);
      check_eq("after_ovf_done", 64'(r_done), 64'd1);

      // T6 and other argument errors.
      run_cmd("write 12345 1", 60);
      expect_err("addr_long", 3'd2);
      run_cmd("foo", 20);
      expect_err("unknown", 3'd1);
      run_cmd("start ", 20);
      expect_err("start_space", 3'd1);
      run_cmd("write 1A", 40);
      expect_err("write_nodata", 3'd2);
      run_cmd("read 1 2", 40);
      expect_err("read_extra", 3'd2);
      run_cmd("read 1G", 40);
      expect_err("read_nonhex", 3'd2);
      run_cmd("write 1 123456789", 60);
      expect_err("data_long", 3'd2);

      // Empty line is silently ignored.
      send_byte(8'h0D);
      send_byte(8'h0A);
      wait_result(10);
      check_eq("empty_line", 64'({r_done, r_err}), 64'd0);

      // Asynchronous reset in the middle of a write.
      run_cmd("write 5 7", 15);
      check_eq("mid_write_cs", 64'(bus_if.cs), 64'd1);
      check_eq("mid_write_addr", 64'(bus_if.addr), 64'h0005);
      #2 rst = 1'b1;
      #1;
      check_eq("async_cs", 64'(bus_if.cs), 64'd0);
      check_eq("async_we", 64'(bus_if.we), 64'd0);
      check_eq("async_irq", 64'(irq), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      run_cmd("start", 20);
      check_eq("post_rst_start", 64'(r_done), 64'd1);
      check_eq("post_rst_irq", 64'(irq), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
